// File: rtl/debounce_pkg.sv
// Shared constants for the debounce_sync block.
//   ST_IDLE / ST_COUNT : filter state encoding (1-bit)
//   DEF_*              : default parameter values for debounce_sync
package debounce_pkg;

    typedef logic state_t;

    localparam state_t ST_IDLE  = 1'b0;
    localparam state_t ST_COUNT = 1'b1;

    localparam int unsigned DEF_SYNC_STAGES   = 2;
    localparam int unsigned DEF_CNT_W         = 16;
    localparam int unsigned DEF_STABLE_CYCLES = 50000;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer that brings an asynchronous level into the clk domain.
//   clk : rising-edge clock
//   rst : synchronous active-high reset, clears every stage to 0
//   d   : asynchronous input
//   q   : synchronized output (last stage)
module sync_chain #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    // Pure shift register: nothing may sit between the flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Debouncer: synchronizes a raw input, then only accepts a new level after it
// has been sampled STABLE_CYCLES times in a row; emits one-cycle edge pulses.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   din  : raw asynchronous input
//   dout : debounced level (registered)
//   rise : one-cycle pulse when dout goes 0->1 (registered)
//   fall : one-cycle pulse when dout goes 1->0 (registered)
//   busy : synchronized input differs from dout (status only, from registers)
module debounce_sync
    import debounce_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int unsigned CNT_W         = DEF_CNT_W,
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             din_s;
    state_t           st_q;
    logic [CNT_W-1:0] cnt_q;
    logic             dout_q;
    logic             rise_q;
    logic             fall_q;

    logic             mismatch;
    logic [CNT_W-1:0] cnt_cur;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (din),
        .q   (din_s)
    );

    assign mismatch = (din_s != dout_q);

    // IDLE always holds a zero count, so the window starts fresh on entry.
    assign cnt_cur = (st_q == ST_COUNT) ? cnt_q : '0;

    // Stability filter and edge pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q   <= ST_IDLE;
            cnt_q  <= '0;
            dout_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            if (!mismatch) begin
                // Matching sample: abandon any window in progress.
                st_q  <= ST_IDLE;
                cnt_q <= '0;
            end else if (cnt_cur == CNT_LAST) begin
                // Final sample of a full window: accept the new level.
                st_q   <= ST_IDLE;
                cnt_q  <= '0;
                dout_q <= din_s;
                rise_q <= din_s;
                fall_q <= ~din_s;
            end else begin
                st_q  <= ST_COUNT;
                cnt_q <= cnt_cur + CNT_W'(1);
            end
        end
    end

    assign dout = dout_q;
    assign rise = rise_q;
    assign fall = fall_q;
    assign busy = mismatch;

endmodule

// File: tb/tb_debounce_sync.sv
// Bench for debounce_sync: instance 0 uses a 4-sample window, instance 1 a
// 1-sample window; both are checked every cycle against a window model.
module tb_debounce_sync;

    localparam int unsigned SYNC = 2;

    logic clk = 1'b0;
    logic rst;
    logic din0, din1;
    logic dout0, rise0, fall0, busy0;
    logic dout1, rise1, fall1, busy1;

    always #5 clk = ~clk;

    debounce_sync #(
        .SYNC_STAGES   (SYNC),
        .CNT_W         (3),
        .STABLE_CYCLES (4)
    ) u_dut0 (
        .clk  (clk),
        .rst  (rst),
        .din  (din0),
        .dout (dout0),
        .rise (rise0),
        .fall (fall0),
        .busy (busy0)
    );

    debounce_sync #(
        .SYNC_STAGES   (SYNC),
        .CNT_W         (3),
        .STABLE_CYCLES (1)
    ) u_dut1 (
        .clk  (clk),
        .rst  (rst),
        .din  (din1),
        .dout (dout1),
        .rise (rise1),
        .fall (fall1),
        .busy (busy1)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // The synchronizer is a plain delay line; the filter accepts a new level
    // once the last N filter samples (all taken since the previous change)
    // all differ from the current output.
    bit ms   [0:1][0:SYNC-1];
    bit win  [0:1][0:3];
    int wlen [0:1];
    bit md   [0:1];
    bit mr   [0:1];
    bit mf   [0:1];
    bit m_d, m_s, m_hit;
    int m_n;

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            m_d = (k == 0) ? din0 : din1;
            m_n = (k == 0) ? 4 : 1;
            if (rst) begin
                for (int i = 0; i < SYNC; i++) ms[k][i] = 1'b0;
                wlen[k] = 0;
                md[k] = 1'b0;
                mr[k] = 1'b0;
                mf[k] = 1'b0;
            end else begin
                m_s = ms[k][SYNC-1];
                for (int i = SYNC-1; i > 0; i--) ms[k][i] = ms[k][i-1];
                ms[k][0] = m_d;
                for (int i = 3; i > 0; i--) win[k][i] = win[k][i-1];
                win[k][0] = m_s;
                if (wlen[k] < m_n) wlen[k]++;
                mr[k] = 1'b0;
                mf[k] = 1'b0;
                m_hit = (wlen[k] == m_n);
                for (int i = 0; i < m_n; i++) if (win[k][i] == md[k]) m_hit = 1'b0;
                if (m_hit) begin
                    md[k] = m_s;
                    mr[k] = m_s;
                    mf[k] = !m_s;
                    wlen[k] = 0;
                end
            end
        end
    endtask

    always @(posedge clk) model_step();

    // ---------------- per-cycle compare ----------------
    bit chk_en = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("dout0", 32'(dout0), 32'(md[0]));
            check("rise0", 32'(rise0), 32'(mr[0]));
            check("fall0", 32'(fall0), 32'(mf[0]));
            check("busy0", 32'(busy0), 32'(ms[0][SYNC-1] ^ md[0]));
            check("dout1", 32'(dout1), 32'(md[1]));
            check("rise1", 32'(rise1), 32'(mr[1]));
            check("fall1", 32'(fall1), 32'(mf[1]));
            check("busy1", 32'(busy1), 32'(ms[1][SYNC-1] ^ md[1]));
            check("pulse_excl0", 32'(rise0 & fall0), 32'd0);
            check("pulse_excl1", 32'(rise1 & fall1), 32'd0);
        end
    end

    // ---------------- directed helpers ----------------
    // Waits for dout of instance k to reach v; returns edges taken (-1 on timeout).
    task automatic wait_dout(input int k, input logic v, input string name, input int exp_n);
        int n;
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (((k == 0) ? dout0 : dout1) === v) begin
                n = i;
                break;
            end
        end
        check(name, 32'(n), 32'(exp_n));
    endtask

    // Drives pat[i] on din0 before edge i (holding the last value), and
    // reports the first edge count where dout0 changed plus pulse/busy counts.
    task automatic observe(input logic [15:0] pat, input int plen, input int cycles,
                           output int chg, output int nr, output int nf, output int nb);
        logic d0;
        d0 = dout0;
        chg = 0; nr = 0; nf = 0; nb = 0;
        for (int i = 0; i < cycles; i++) begin
            din0 = (i < plen) ? pat[i] : pat[plen-1];
            @(negedge clk);
            if (busy0 === 1'b1) nb++;
            if (rise0 === 1'b1) nr++;
            if (fall0 === 1'b1) nf++;
            if (chg == 0 && dout0 !== d0) chg = i + 1;
        end
    endtask

    int chg, nr, nf, nb, first;

    initial begin
        rst  = 1'b1;
        din0 = 1'b0;
        din1 = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);

        // Reset held with din high, then release: full latency to rise.
        din0 = 1'b1;
        repeat (2) @(negedge clk);
        check("t1_dout_in_reset", 32'(dout0), 32'd0);
        check("t1_busy_in_reset", 32'(busy0), 32'd0);
        rst = 1'b0;
        wait_dout(0, 1'b1, "t1_rise_latency", 6);
        check("t1_rise_pulse", 32'(rise0), 32'd1);
        check("t1_fall_quiet", 32'(fall0), 32'd0);
        @(negedge clk);
        check("t1_rise_clears", 32'(rise0), 32'd0);
        repeat (3) @(negedge clk);

        // Clean 1->0 change.
        observe(16'b0, 1, 10, chg, nr, nf, nb);
        check("t2_fall_latency", 32'(chg), 32'd6);
        check("t2_fall_count", 32'(nf), 32'd1);
        check("t2_busy_cycles", 32'(nb), 32'd4);
        check("t2_rise_count", 32'(nr), 32'd0);

        // Three-cycle pulse is rejected.
        observe(16'b0000_0000_0000_0111, 4, 12, chg, nr, nf, nb);
        check("t3_no_change", 32'(chg), 32'd0);
        check("t3_rise_count", 32'(nr), 32'd0);
        check("t3_busy_cycles", 32'(nb), 32'd3);

        // Single-sample glitch restarts the window.
        observe(16'b0000_0000_1111_0111, 8, 16, chg, nr, nf, nb);
        check("t4_rise_latency", 32'(chg), 32'd10);
        check("t4_rise_count", 32'(nr), 32'd1);
        check("t4_busy_cycles", 32'(nb), 32'd7);

        // Reset mid-count aborts the pending change.
        din0 = 1'b0;
        repeat (10) @(negedge clk);
        check("t5_pre_low", 32'(dout0), 32'd0);
        din0 = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t5_dout_after_rst", 32'(dout0), 32'd0);
        check("t5_rise_after_rst", 32'(rise0), 32'd0);
        rst = 1'b0;
        wait_dout(0, 1'b1, "t5_rise_latency", 6);
        check("t5_rise_pulse", 32'(rise0), 32'd1);

        // One-sample window: output tracks input three edges later.
        for (int t = 0; t < 6; t++) begin
            din1 = ~din1;
            first = 0;
            nr = 0;
            nf = 0;
            for (int j = 1; j <= 3; j++) begin
                @(negedge clk);
                if (first == 0 && dout1 === din1) first = j;
                if (rise1 === 1'b1) nr++;
                if (fall1 === 1'b1) nf++;
            end
            check("t6_track_latency", 32'(first), 32'd3);
            check("t6_pulse_count", 32'(nr + nf), 32'd1);
            check("t6_pulse_dir", 32'(nr), 32'(din1));
        end

        // Randomized bursts with occasional resets.
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 5) == 0) din0 = ~din0;
            din1 = 1'($urandom_range(0, 1));
            rst  = ($urandom_range(0, 119) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        repeat (10) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/debounce_sync.md
Name: debounce_sync

Overview:
- Conditions a raw asynchronous input (push-button, switch, external strobe) into a clean, glitch-free, clock-synchronous level plus single-cycle edge pulses.
- Sits directly upstream of the team's D flip-flop and register stages; its `dout`/`rise` outputs are the `d`/enable inputs those stages consume.
- Contains a metastability synchronizer chain followed by a counter-based stability filter and an edge detector.

Parameters:
- SYNC_STAGES, 2: number of synchronizer flops; legal range is 2 or more.
- CNT_W, 16: stability counter width.
- STABLE_CYCLES, 50000: consecutive clk samples of a new level required before `dout` changes; legal range is 1 to 2^CNT_W-1.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- din  in  1  raw asynchronous input
- dout  out  1  debounced, synchronized level (registered)
- rise  out  1  one-cycle pulse, coincident with `dout` going 0->1 (registered)
- fall  out  1  one-cycle pulse, coincident with `dout` going 1->0 (registered)
- busy  out  1  high while the synchronized input differs from `dout` (combinational from registers)

Behaviour:
- Clock and reset
  - One clock domain.
  - Reset is synchronous and active-high; it is sampled only on the rising edge of clk and takes priority over all other logic.
- Reset values: sync chain all 0, counter 0, `dout`=0, `rise`=0, `fall`=0. `busy` follows from these (0 once `din_s`=0).
- Synchronizer
  - `din` shifts through SYNC_STAGES flops. The last stage is `din_s`.
  - No logic is permitted between synchronizer flops.
- Filter states (1-bit state)
  - IDLE: `din_s`==`dout`, counter held at 0.
  - COUNT: `din_s`!=`dout`, counter increments every cycle.
- Transitions
  - IDLE->COUNT when `din_s`!=`dout`.
  - COUNT->IDLE when `din_s`==`dout` (glitch). Counter clears to 0 on the same edge and `dout` is unchanged.
  - COUNT with counter==STABLE_CYCLES-1 and `din_s`!=`dout`: on that edge `dout`<=`din_s`, counter<=0, state->IDLE.
  - On that same edge `rise`<=`din_s`, and `fall`<=~`din_s`.
- Pulses: `rise`/`fall` are high for exactly one cycle and never both high; they deassert on the next edge.
- Latency: after `din` changes before edge E0 and then holds, `dout` changes on edge E(SYNC_STAGES+STABLE_CYCLES-1), i.e. the (SYNC_STAGES+STABLE_CYCLES)-th rising edge.
- STABLE_CYCLES=1: `dout` follows `din_s` with one cycle of delay; pulses still generated.
- Glitch boundary: any single matching sample during COUNT restarts the full STABLE_CYCLES window.
- Counter never exceeds STABLE_CYCLES-1; no wrap-around is possible.
- Reset mid-count: counter, `dout` and pulses clear; no pulse is emitted for the aborted transition.
- `din` held 1 through reset deassert: a normal `rise` is produced after the full latency.
- `busy`=(`din_s`!=`dout`). It is for status/LED use only and must not gate other logic.

Decomposition:
- Package debounce_pkg holds:
  - state encoding localparams ST_IDLE=1'b0, ST_COUNT=1'b1
  - default constants for SYNC_STAGES and STABLE_CYCLES
- One sub-module, sync_chain (parameter STAGES; ports clk, rst, d, q), instantiated once. It is reused wherever the team crosses an asynchronous input into the clk domain.
- The filter, state and edge logic stay in debounce_sync.

Test Plan (SYNC_STAGES=2, STABLE_CYCLES=4, CNT_W=3):
1. Assert rst 2 cycles with `din`=1, then release -> `dout`=0 during reset; `dout`=1 on the 6th edge after release; `rise`=1 for that one cycle; `fall` stays 0.
2. `dout`=1 steady; drive `din`=0 and hold -> `dout` falls exactly 6 edges after the change; `fall` pulses one cycle; `busy` high for 4 cycles, then 0.
3. `dout`=0; pulse `din`=1 for 3 cycles, then 0 -> `dout` stays 0; no `rise`; `busy` high 3 cycles, then 0; counter back to 0.
4. `dout`=0; drive `din` 1,1,1,0,1,1,1,1 (one per cycle) -> the glitch restarts the window; `dout` rises 4 cycles after the final restart plus 2 sync cycles; exactly one `rise`.
5. `din`=1 held; assert rst when the counter reaches 2 -> `dout`, `rise` and counter are 0 next cycle; after release a full 6-edge latency occurs before `rise`.
6. Re-parameterize STABLE_CYCLES=1; toggle `din` every 3 cycles -> `dout` tracks `din` delayed 3 edges; alternating single-cycle `rise`/`fall` pulses, never overlapping.
